// File: rtl/alu_ctrl_mul.sv
// rtl/alu_ctrl_mul.sv - ALU control decoder with iterative shift-add multiplier for mult/multu
// Decode is combinational; the multiplier stalls the datapath for DATA_W+1 cycles per accept.
module alu_ctrl_mul #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [3:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;

    logic [4:0]            code;
    logic                  is_mul;
    logic                  is_signed;
    logic [DATA_W-1:0]     mag1;
    logic [DATA_W-1:0]     mag2;
    logic [2*DATA_W-1:0]   acc_sum;
    logic [2*DATA_W-1:0]   prod;

    always_comb begin
        code = 5'd0;
        if (ALUOp_i == 4'd0) begin
            case (funct_i)
                6'd32:   code = 5'd0;
                6'd34:   code = 5'd2;
                6'd36:   code = 5'd3;
                6'd37:   code = 5'd4;
                6'd42:   code = 5'd5;
                6'd2:    code = 5'd11;
                6'd6:    code = 5'd12;
                6'd24:   code = 5'd16;
                6'd25:   code = 5'd19;
                default: code = 5'd0;
            endcase
        end else begin
            case (ALUOp_i)
                4'd1:    code = 5'd7;
                4'd2:    code = 5'd1;
                4'd3:    code = 5'd6;
                4'd4:    code = 5'd8;
                4'd5:    code = 5'd9;
                4'd6:    code = 5'd10;
                4'd7:    code = 5'd13;
                4'd8:    code = 5'd14;
                4'd9:    code = 5'd15;
                4'd10:   code = 5'd17;
                4'd11:   code = 5'd18;
                default: code = 5'd0;
            endcase
        end
    end

    assign ALUCtrl_o = CTRL_W'(code);
    assign is_mul    = (ALUOp_i == 4'd0) && ((funct_i == 6'd24) || (funct_i == 6'd25));
    assign is_signed = (funct_i == 6'd24);

    // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign mag1    = (is_signed && src1_i[DATA_W-1]) ? -src1_i : src1_i;
    assign mag2    = (is_signed && src2_i[DATA_W-1]) ? -src2_i : src2_i;
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod    = neg_q ? -acc_sum : acc_sum;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i && is_mul) begin
                    state_d  = S_BUSY;
                    mcand_d  = {{DATA_W{1'b0}}, mag1};
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = is_signed & (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
                end
            end
            S_BUSY: begin
                // Multiplicand is pre-shifted each step, so it always carries weight 2^cnt.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = prod;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign stall_o = !rst_i & (((state_q == S_IDLE) & valid_i & is_mul) | (state_q == S_BUSY));
    assign done_o  = (state_q == S_DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
endmodule
